dma_rr_arbiter: RTL and testbench

N-channel DMA bus arbiter, the parametrised successor of the two-requester IDLE/GNT0/GNT1 grant FSM. Supports a selectable fixed-priority or round-robin policy and a per-grant burst limit that forces a hold-over owner to release the bus. Sits between the DMA channel request logic and the shared bus master port. Drives a registered one-hot grant plus an encoded owner ID.

---
 rtl/dma_rr_arbiter_if.sv | 27 ++
 rtl/dma_rr_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dma_rr_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/dma_rr_arbiter_if.sv
// Request/grant bundle between the DMA channel request logic and the bus arbiter.
// The master side drives requests and policy; the slave (arbiter) side returns the grant.
interface dma_rr_arbiter_if #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned BURST_MAX = 8
);
  localparam int unsigned ID_W  = $clog2(NUM_CH);
  localparam int unsigned CNT_W = $clog2(BURST_MAX + 1);

  logic [NUM_CH-1:0] req;
  logic              mode;
  logic [NUM_CH-1:0] gnt;
  logic [ID_W-1:0]   gnt_id;
  logic              gnt_valid;
  logic [CNT_W-1:0]  hold_cnt;
  logic              expired;

  modport master (
    output req, mode,
    input  gnt, gnt_id, gnt_valid, hold_cnt, expired
  );

  modport slave (
    input  req, mode,
    output gnt, gnt_id, gnt_valid, hold_cnt, expired
  );
endinterface

// File: rtl/dma_rr_arbiter.sv
// N-channel DMA bus arbiter: fixed-priority or round-robin selection with a
// per-ownership burst limit that forces a still-requesting owner off the bus.
module dma_rr_arbiter #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned BURST_MAX = 8
) (
  input  logic             clock,
  input  logic             reset,
  dma_rr_arbiter_if.slave  bus
);
  localparam int unsigned ID_W  = $clog2(NUM_CH);
  localparam int unsigned CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic              expired_q, expired_d;
  logic [ID_W-1:0]   last_owner_q, last_owner_d;

  logic [NUM_CH-1:0] last_oh;
  logic [NUM_CH-1:0] cand;
  logic              cand_any;
  logic [ID_W-1:0]   win_fix;
  logic [ID_W-1:0]   win_rr;
  logic [ID_W-1:0]   win;
  logic              do_grant;
  logic [ID_W-1:0]   grant_id;

  // Winner selection; in RELEASE the previous owner is excluded from the candidates
  always_comb begin
    last_oh  = NUM_CH'(1) << last_owner_q;
    cand     = (state_q == RELEASE) ? (bus.req & ~last_oh) : bus.req;
    cand_any = |cand;

    win_fix = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (cand[ID_W'(i)]) win_fix = ID_W'(i);
    end

    // Descending search distance so the nearest index after last_owner wins
    win_rr = '0;
    for (int unsigned k = NUM_CH; k >= 1; k--) begin
      int unsigned idx;
      idx = (32'(last_owner_q) + k) % NUM_CH;
      if (cand[ID_W'(idx)]) win_rr = ID_W'(idx);
    end

    win = bus.mode ? win_rr : win_fix;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    gnt_id_d     = gnt_id_q;
    gnt_valid_d  = gnt_valid_q;
    hold_cnt_d   = hold_cnt_q;
    expired_d    = 1'b0;
    last_owner_d = last_owner_q;
    do_grant     = 1'b0;
    grant_id     = '0;

    case (state_q)
      IDLE: begin
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        hold_cnt_d  = '0;
        if (cand_any) begin
          do_grant = 1'b1;
          grant_id = win;
        end
      end

      GRANT: begin
        if (!bus.req[gnt_id_q]) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = '0;
        end else if (hold_cnt_q < BURST_LIM) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end else begin
          state_d     = RELEASE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = '0;
          expired_d   = 1'b1;
        end
      end

      RELEASE: begin
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        hold_cnt_d  = '0;
        state_d     = IDLE;
        if (cand_any) begin
          do_grant = 1'b1;
          grant_id = win;
        end else if (bus.req[last_owner_q]) begin
          do_grant = 1'b1;
          grant_id = last_owner_q;
        end
      end

      default: begin
        state_d     = IDLE;
        gnt_d       = '0;
        gnt_id_d    = '0;
        gnt_valid_d = 1'b0;
        hold_cnt_d  = '0;
      end
    endcase

    if (do_grant) begin
      state_d      = GRANT;
      gnt_d        = NUM_CH'(1) << grant_id;
      gnt_id_d     = grant_id;
      gnt_valid_d  = 1'b1;
      hold_cnt_d   = CNT_W'(1);
      last_owner_d = grant_id;
    end
  end

  // Last owner resets to the top channel so channel 0 wins the first round-robin pass
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      gnt_id_q     <= '0;
      gnt_valid_q  <= 1'b0;
      hold_cnt_q   <= '0;
      expired_q    <= 1'b0;
      last_owner_q <= ID_W'(NUM_CH - 1);
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      gnt_id_q     <= gnt_id_d;
      gnt_valid_q  <= gnt_valid_d;
      hold_cnt_q   <= hold_cnt_d;
      expired_q    <= expired_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.hold_cnt  = hold_cnt_q;
  assign bus.expired   = expired_q;

endmodule

// File: tb/tb_dma_rr_arbiter.sv
// Directed bench for dma_rr_arbiter: per-cycle vectors feed a scoreboard queue
// that a monitor drains just after each rising edge.
module tb_dma_rr_arbiter;
  localparam int unsigned NUM_CH    = 4;
  localparam int unsigned BURST_MAX = 8;

  typedef struct packed {
    logic       rst;
    logic       mode;
    logic [3:0] req;
  } stim_t;

  typedef struct packed {
    logic [3:0] gnt;
    logic [3:0] hold;
    logic       expd;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  dma_rr_arbiter_if #(.NUM_CH(NUM_CH), .BURST_MAX(BURST_MAX)) bus ();

  dma_rr_arbiter #(.NUM_CH(NUM_CH), .BURST_MAX(BURST_MAX)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  stim_t stim_q[$];
  exp_t  vec_q[$];
  exp_t  sb_q[$];
  int    errors = 0;
  int    checks = 0;

  task automatic add(input logic rst, input logic mode, input logic [3:0] req,
                     input logic [3:0] gnt, input logic [3:0] hold, input logic expd);
    stim_t s;
    exp_t  e;
    s.rst = rst;  s.mode = mode; s.req = req;
    e.gnt = gnt;  e.hold = hold; e.expd = expd;
    stim_q.push_back(s);
    vec_q.push_back(e);
  endtask

  function automatic logic [1:0] oh2id(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  // Monitor: compare every output just after the edge the vector was sampled on
  always @(posedge clock) begin
    #1;
    if (sb_q.size() > 0) begin
      exp_t e;
      logic ok;
      e  = sb_q.pop_front();
      ok = (bus.gnt === e.gnt) && (bus.gnt_valid === (|e.gnt)) &&
           (bus.hold_cnt === e.hold) && (bus.expired === e.expd);
      if (|e.gnt) ok = ok && (bus.gnt_id === oh2id(e.gnt));
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL check#%0d t=%0t: got gnt=%b id=%0d v=%b hold=%0d exp=%b, want gnt=%b id=%0d v=%b hold=%0d exp=%b",
                 checks, $time, bus.gnt, bus.gnt_id, bus.gnt_valid, bus.hold_cnt, bus.expired,
                 e.gnt, oh2id(e.gnt), |e.gnt, e.hold, e.expd);
      end
    end
  end

  initial begin
    reset    = 1'b1;
    bus.req  = '0;
    bus.mode = 1'b0;

    // Reset held with all channels requesting, then channel 0 wins
    add(1, 0, 4'b1111, 4'b0000, 0, 0);
    add(1, 0, 4'b1111, 4'b0000, 0, 0);
    add(0, 0, 4'b1111, 4'b0001, 1, 0);
    add(0, 0, 4'b0000, 4'b0000, 0, 0);
    add(0, 0, 4'b0000, 4'b0000, 0, 0);

    // Fixed priority: ch1 over ch3, dead cycle, then ch3
    for (int i = 1; i <= 3; i++) add(0, 0, 4'b1010, 4'b0010, 4'(i), 0);
    add(0, 0, 4'b1000, 4'b0000, 0, 0);
    add(0, 0, 4'b1000, 4'b1000, 1, 0);
    add(0, 0, 4'b0000, 4'b0000, 0, 0);

    // Round robin rotation; mode flip mid-grant must not matter
    add(0, 1, 4'b1111, 4'b0001, 1, 0);
    add(0, 0, 4'b1110, 4'b0000, 0, 0);
    add(0, 1, 4'b1111, 4'b0010, 1, 0);
    add(0, 1, 4'b1101, 4'b0000, 0, 0);
    add(0, 1, 4'b1111, 4'b0100, 1, 0);
    add(0, 1, 4'b1011, 4'b0000, 0, 0);
    add(0, 1, 4'b1111, 4'b1000, 1, 0);
    add(0, 1, 4'b0111, 4'b0000, 0, 0);
    add(0, 1, 4'b1111, 4'b0001, 1, 0);
    add(0, 0, 4'b1111, 4'b0001, 2, 0);
    add(0, 1, 4'b0000, 4'b0000, 0, 0);

    // Burst limit with two fixed-priority requesters
    for (int i = 1; i <= 8; i++) add(0, 0, 4'b0011, 4'b0001, 4'(i), 0);
    add(0, 0, 4'b0011, 4'b0000, 0, 1);
    for (int i = 1; i <= 8; i++) add(0, 0, 4'b0011, 4'b0010, 4'(i), 0);
    add(0, 0, 4'b0011, 4'b0000, 0, 1);
    add(0, 0, 4'b0011, 4'b0001, 1, 0);
    add(0, 0, 4'b0000, 4'b0000, 0, 0);

    // Lone requester repeatedly expires and is re-granted
    for (int r = 0; r < 2; r++) begin
      for (int i = 1; i <= 8; i++) add(0, 0, 4'b0100, 4'b0100, 4'(i), 0);
      add(0, 0, 4'b0100, 4'b0000, 0, 1);
    end
    add(0, 0, 4'b0100, 4'b0100, 1, 0);
    add(0, 0, 4'b0100, 4'b0100, 2, 0);
    add(0, 0, 4'b0000, 4'b0000, 0, 0);

    // Reset mid-burst, then round robin restarts at channel 0
    for (int i = 1; i <= 5; i++) add(0, 0, 4'b0010, 4'b0010, 4'(i), 0);
    add(1, 0, 4'b0010, 4'b0000, 0, 0);
    add(0, 1, 4'b0011, 4'b0001, 1, 0);
    add(0, 1, 4'b0000, 4'b0000, 0, 0);

    // Driver: apply each vector on the falling edge and post its expectation
    while (stim_q.size() > 0) begin
      stim_t s;
      exp_t  e;
      s = stim_q.pop_front();
      e = vec_q.pop_front();
      @(negedge clock);
      reset    = s.rst;
      bus.mode = s.mode;
      bus.req  = s.req;
      sb_q.push_back(e);
    end

    for (int n = 0; n < 20 && sb_q.size() > 0; n++) @(posedge clock);
    #2;
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
